// File: rtl/rst_sequencer_pkg.sv
// rst_sequencer_pkg: state and reset-cause types shared by the reset sequencer files
package rst_sequencer_pkg;
  typedef enum logic [2:0] {
    StWaitLock,
    StPeriphHold,
    StCoreHold,
    StRun,
    StAssert
  } rst_seq_state_e;
  typedef enum logic [1:0] {
    RstCausePor,
    RstCauseLock,
    RstCauseBtn,
    RstCauseSw
  } rst_cause_e;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/rst_btn_debounce.sv
// rst_btn_debounce: synchronizes the reset button and emits one pulse per qualified press
module rst_btn_debounce #(
  parameter int DebounceCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DebounceCycles + 1);
  localparam logic [CW-1:0] Target = CW'(DebounceCycles);
  localparam logic [CW-1:0] Arm = CW'(DebounceCycles - 1);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_pulse;
  logic w_btn;
  assign w_btn = r_sync[1];
  assign pulse_o = r_pulse;
  // the counter saturates at Target, so a held button never fires twice
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn_i};
      r_cnt <= !w_btn ? '0 : (r_cnt == Target ? r_cnt : r_cnt + 1'b1);
      r_pulse <= w_btn && r_cnt == Arm;
    end
  end
endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: releases peripheral then core reset after PLL lock and records the last reset cause
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int PeriphHoldCycles = 16,
  parameter int CoreHoldCycles   = 16,
  parameter int AssertCycles     = 32,
  parameter int DebounceCycles   = 1024
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_ni,
  input  logic       pll_locked_i,
  input  logic       ext_rst_req_i,
  input  logic       sw_rst_req_i,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic [1:0] rst_cause_o,
  output logic       seq_busy_o
);
  localparam int CW = $clog2(max3(PeriphHoldCycles, CoreHoldCycles, AssertCycles)) + 1;
  localparam logic [CW-1:0] PLoad = CW'(PeriphHoldCycles - 1);
  localparam logic [CW-1:0] CLoad = CW'(CoreHoldCycles - 1);
  localparam logic [CW-1:0] ALoad = CW'(AssertCycles - 1);
  logic [1:0] r_lock_sync;
  logic [CW-1:0] r_cnt;
  logic r_periph_n, r_core_n, r_busy;
  rst_seq_state_e r_state, w_nxt;
  rst_cause_e r_cause, w_cause;
  logic [CW-1:0] w_load;
  logic w_lock, w_btn, w_cnt_done, w_lost, w_btn_hit, w_sw_hit;
  rst_btn_debounce #(.DebounceCycles(DebounceCycles)) u_btn (
    .clk_i  (clk_sys_i),
    .rst_ni (rst_sys_ni),
    .btn_i  (ext_rst_req_i),
    .pulse_o(w_btn)
  );
  assign w_lock = r_lock_sync[1];
  assign w_cnt_done = r_cnt == '0;
  assign w_lost = !w_lock && r_state != StWaitLock;
  assign w_btn_hit = w_btn && r_state inside {StPeriphHold, StCoreHold, StRun};
  assign w_sw_hit = sw_rst_req_i && r_state == StRun;
  assign w_load = w_nxt == StPeriphHold ? PLoad :
                  w_nxt == StCoreHold   ? CLoad :
                  w_nxt == StAssert     ? ALoad : '0;
  assign rst_periph_no = r_periph_n;
  assign rst_core_no = r_core_n;
  assign rst_cause_o = r_cause;
  assign seq_busy_o = r_busy;
  // request priority: lock loss, then button, then software
  always_comb begin
    w_nxt = r_state;
    w_cause = r_cause;
    if (w_lost) begin
      w_nxt = StWaitLock;
      w_cause = RstCauseLock;
    end else if (w_btn_hit) begin
      w_nxt = StAssert;
      w_cause = RstCauseBtn;
    end else if (w_sw_hit) begin
      w_nxt = StAssert;
      w_cause = RstCauseSw;
    end else begin
      case (r_state)
        StWaitLock:   w_nxt = w_lock ? StPeriphHold : StWaitLock;
        StPeriphHold: w_nxt = w_cnt_done ? StCoreHold : StPeriphHold;
        StCoreHold:   w_nxt = w_cnt_done ? StRun : StCoreHold;
        StAssert:     w_nxt = w_cnt_done ? StWaitLock : StAssert;
        StRun:        w_nxt = StRun;
        default:      w_nxt = StWaitLock;
      endcase
    end
  end
  // outputs decode the next state so they move on the same edge as the state
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_lock_sync <= '0;
      r_state <= StWaitLock;
      r_cause <= RstCausePor;
      r_cnt <= '0;
      r_periph_n <= 1'b0;
      r_core_n <= 1'b0;
      r_busy <= 1'b1;
    end else begin
      r_lock_sync <= {r_lock_sync[0], pll_locked_i};
      r_state <= w_nxt;
      r_cause <= w_cause;
      r_cnt <= w_nxt != r_state ? w_load : (w_cnt_done ? r_cnt : r_cnt - 1'b1);
      r_periph_n <= w_nxt inside {StCoreHold, StRun};
      r_core_n <= w_nxt == StRun;
      r_busy <= w_nxt != StRun;
    end
  end
endmodule
